shift_seq_ctrl: RTL and testbench

//  Multi-cycle 16-bit shifter front end. It latches a value, an opcode and a 4-bit count,

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_stage.sv | 31 +++
 rtl/shift_seq_ctrl.sv | 92 +++++++++
 tb/tb_shift_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shifter front end.
//   WIDTH  : data width (stage wiring is fixed, so only 16 is legal)
//   CNT_W  : shift-count width, log2(WIDTH)
//   OP_*   : opcode encodings
//   state_e: controller state encoding
package shift_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StS8   = 3'd1,
    StS4   = 3'd2,
    StS2   = 3'd3,
    StS1   = 3'd4,
    StDone = 3'd5
  } state_e;

endpackage

// File: rtl/shift_stage.sv
// One fixed-amount shift stage, purely combinational.
//   in  : operand
//   op  : opcode (ROL, SLL, SRA, SRL)
//   sh  : 1 applies the shift, 0 passes the operand through
//   out : result
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned AMT = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic             sh,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = in;
    unique case (op)
      OP_ROL:  shifted = {in[WIDTH-1-AMT:0], in[WIDTH-1:WIDTH-AMT]};
      OP_SLL:  shifted = {in[WIDTH-1-AMT:0], {AMT{1'b0}}};
      OP_SRA:  shifted = {{AMT{in[WIDTH-1]}}, in[WIDTH-1:AMT]};
      OP_SRL:  shifted = {{AMT{1'b0}}, in[WIDTH-1:AMT]};
      default: shifted = in;
    endcase
    out = sh ? shifted : in;
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle 16-bit shifter front end between issue logic and the writeback mux.
// Latches operand/opcode/count, then applies the 8, 4, 2 and 1 stages on successive
// cycles (each gated by its count bit) and presents the result until it is taken.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake; in_data, in_op, in_cnt carry the request
//   out_valid/out_ready   : result handshake; out_data carries the result
//   busy                  : 1 whenever the controller is not idle
module shift_seq_ctrl
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] s8_out, s4_out, s2_out, s1_out;
  logic             accept;

  // All stages see the current data_q; the FSM picks the one for the current state.
  shift_stage #(.AMT(8)) u_s8 (.in(data_q), .op(op_q), .sh(cnt_q[3]), .out(s8_out));
  shift_stage #(.AMT(4)) u_s4 (.in(data_q), .op(op_q), .sh(cnt_q[2]), .out(s4_out));
  shift_stage #(.AMT(2)) u_s2 (.in(data_q), .op(op_q), .sh(cnt_q[1]), .out(s2_out));
  shift_stage #(.AMT(1)) u_s1 (.in(data_q), .op(op_q), .sh(cnt_q[0]), .out(s1_out));

  // DONE with out_ready drains the result, so a new request can load on the same edge.
  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            data_q  <= in_data;
            op_q    <= in_op;
            cnt_q   <= in_cnt;
            state_q <= StS8;
          end
        end
        StS8: begin
          data_q  <= s8_out;
          state_q <= StS4;
        end
        StS4: begin
          data_q  <= s4_out;
          state_q <= StS2;
        end
        StS2: begin
          data_q  <= s2_out;
          state_q <= StS1;
        end
        StS1: begin
          data_q  <= s1_out;
          state_q <= StDone;
        end
        StDone: begin
          if (accept) begin
            data_q  <= in_data;
            op_q    <= in_op;
            cnt_q   <= in_cnt;
            state_q <= StS8;
          end else if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_op;
  logic [3:0]  in_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  logic [15:0] exp_q[$];

  shift_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_cnt    (in_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: one-shot shift by the full count.
  function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] op,
                                        input logic [3:0] c);
    logic [31:0]        dd;
    logic signed [15:0] sd;
    dd = {d, d} << c;
    sd = d;
    case (op)
      2'b00:   model = dd[31:16];
      2'b01:   model = d << c;
      2'b10:   model = sd >>> c;
      default: model = d >> c;
    endcase
  endfunction

  // Scoreboard: a result is taken on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h, no result expected", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL result: got %h want %h", out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [15:0] d, input logic [1:0] op, input logic [3:0] c);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_cnt   = c;
    exp_q.push_back(model(d, op, c));
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    in_data  = $urandom();
    in_op    = 2'($urandom());
    in_cnt   = 4'($urandom());
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", n);
    end
  endtask

  // Edges after the accept edge until out_valid is seen.
  task automatic measure_latency(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic run_one(input logic [15:0] d, input logic [1:0] op, input logic [3:0] c);
    int lat;
    send(d, op, c);
    measure_latency(lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL latency op=%0d cnt=%0d: got %0d want 4", op, c, lat);
    end
    drain();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = '0;
    in_cnt    = '0;
    out_ready = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h busy=%b ready=%b want 0 0000 0 1",
               out_valid, out_data, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ops();
    out_ready = 1'b1;
    run_one(16'h8001, 2'b10, 4'd4);   // -> F800
    run_one(16'h1234, 2'b00, 4'd8);   // -> 3412
    run_one(16'h8001, 2'b00, 4'd1);   // -> 0003
    run_one(16'h0001, 2'b01, 4'd15);  // -> 8000
    run_one(16'hFFFF, 2'b11, 4'd0);   // -> FFFF
    run_one(16'h7FF0, 2'b10, 4'd15);  // sign 0 -> 0000
    run_one(16'hA5C3, 2'b00, 4'd15);
    run_one(16'hB00B, 2'b11, 4'd7);
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(16'($urandom()), 2'($urandom()), 4'($urandom()));
      drain();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send(16'hC3A5, 2'b10, 4'd5);
    measure_latency(lat);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0] || in_ready !== 1'b0 || busy !== 1'b1)
      begin
        errors++;
        $display("FAIL backpressure cyc%0d: valid=%b data=%h ready=%b busy=%b want 1 %h 0 1",
                 i, out_valid, out_data, in_ready, busy, exp_q[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: in_ready=%b want 1", in_ready);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] d[3];
    logic [1:0]  o[3];
    logic [3:0]  c[3];
    int acc_cyc[3];
    int idx;
    int cyc;
    int start_out;
    d = '{16'h1357, 16'h8642, 16'hF00F};
    o = '{2'b00, 2'b10, 2'b11};
    c = '{4'd3, 4'd9, 4'd4};
    start_out = n_out;
    out_ready = 1'b1;
    idx = 0;
    cyc = 0;
    in_valid = 1'b1;
    in_data = d[0]; in_op = o[0]; in_cnt = c[0];
    exp_q.push_back(model(d[0], o[0], c[0]));
    while (idx < 3 && cyc < 60) begin
      logic acc;
      acc = in_ready;
      tick();
      cyc++;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          in_data = d[idx]; in_op = o[idx]; in_cnt = c[idx];
          exp_q.push_back(model(d[idx], o[idx], c[idx]));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d want 3", idx);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 5) begin
          errors++;
          $display("FAIL b2b_interval%0d: got %0d want 5", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    drain();
    checks++;
    if (n_out - start_out != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 3", n_out - start_out);
    end
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b1;
    send(16'h1234, 2'b01, 4'd3);
    tick();  // now in S4
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset: valid=%b busy=%b ready=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
    exp_q.delete();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL aborted_result: out_valid=%b want 0", out_valid);
      end
    end
    run_one(16'h8001, 2'b10, 4'd4);
  endtask

  initial begin
    test_reset();
    test_ops();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
